// File: rtl/data_sram_like_bridge_if.sv
// Signal bundle between the CPU data SRAM port, the bridge and the sram-like slave.
// The master modport is the bridge's view: the master of the sram-like bus.
interface data_sram_like_bridge_if;
  // CPU-side SRAM port
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        cpu_longest_stall;
  logic        d_stall;
  // sram-like request/response
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata,
    input  cpu_longest_stall,
    output d_stall,
    output data_req,
    output data_wr,
    output data_size,
    output data_addr,
    output data_wdata,
    input  data_addr_ok,
    input  data_data_ok,
    input  data_rdata
  );

  modport slave (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata,
    output cpu_longest_stall,
    input  d_stall,
    input  data_req,
    input  data_wr,
    input  data_size,
    input  data_addr,
    input  data_wdata,
    output data_addr_ok,
    output data_data_ok,
    output data_rdata
  );
endinterface

// File: rtl/data_sram_like_bridge.sv
// Converts the CPU's single-cycle data SRAM access into one sram-like req/addr_ok/data_ok
// transaction, stalling the pipeline while it is outstanding and holding load data afterwards.
module data_sram_like_bridge #(
  parameter bit READ_WORD_ALIGN = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetn,
  data_sram_like_bridge_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        req_r, req_s;
  logic        wr_r, wr_s;
  logic [1:0]  size_r, size_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] wdata_r, wdata_s;
  logic [31:0] rdata_r, rdata_s;
  logic        d_stall_s;

  // Unrecognised multi-byte enable patterns fall back to a full word store.
  function automatic logic [1:0] size_decode(input logic [3:0] wen);
    logic [1:0] size;
    case (wen)
      4'b1111:                            size = 2'd2;
      4'b0011, 4'b1100:                   size = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
      default:                            size = 2'd2;
    endcase
    return size;
  endfunction

  // Next-state, request-field and load-data selection.
  always_comb begin
    state_s   = state_r;
    req_s     = req_r;
    wr_s      = wr_r;
    size_s    = size_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    rdata_s   = rdata_r;
    d_stall_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.data_sram_en) begin
          state_s   = ST_REQ;
          req_s     = 1'b1;
          wr_s      = |bus.data_sram_wen;
          wdata_s   = bus.data_sram_wdata;
          d_stall_s = 1'b1;
          if (|bus.data_sram_wen) begin
            size_s = size_decode(bus.data_sram_wen);
            addr_s = bus.data_sram_addr;
          end else if (READ_WORD_ALIGN) begin
            size_s = 2'd2;
            addr_s = {bus.data_sram_addr[31:2], 2'b00};
          end else begin
            size_s = 2'd2;
            addr_s = bus.data_sram_addr;
          end
        end else begin
          state_s   = ST_IDLE;
          d_stall_s = 1'b0;
        end
      end
      ST_REQ: begin
        d_stall_s = 1'b1;
        if (bus.data_addr_ok) begin
          req_s = 1'b0;
          // A slave may complete in the accepting cycle; skip WAIT then.
          if (bus.data_data_ok) begin
            state_s = ST_DONE;
            if (!wr_r) begin
              rdata_s = bus.data_rdata;
            end else begin
              rdata_s = rdata_r;
            end
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        d_stall_s = 1'b1;
        if (bus.data_data_ok) begin
          state_s = ST_DONE;
          if (!wr_r) begin
            rdata_s = bus.data_rdata;
          end else begin
            rdata_s = rdata_r;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        // data_sram_en is still high for the finished instruction here and must not relaunch.
        d_stall_s = 1'b0;
        if (!bus.cpu_longest_stall) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        req_s     = 1'b0;
        d_stall_s = 1'b0;
      end
    endcase
  end

  // State and registered bus outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      req_r   <= 1'b0;
      wr_r    <= 1'b0;
      size_r  <= 2'd0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
    end else begin
      state_r <= state_s;
      req_r   <= req_s;
      wr_r    <= wr_s;
      size_r  <= size_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      rdata_r <= rdata_s;
    end
  end

  assign bus.data_req        = req_r;
  assign bus.data_wr         = wr_r;
  assign bus.data_size       = size_r;
  assign bus.data_addr       = addr_r;
  assign bus.data_wdata      = wdata_r;
  assign bus.data_sram_rdata = rdata_r;
  assign bus.d_stall         = d_stall_s;

endmodule
